// File: rtl/cm0_dap_cdc_send_chan.sv
// CDC launch channel: small FIFO feeding a glitch-free launch register,
// qualified by a 4-phase REQ/ACK handshake with a synchronised ACK.
module cm0_dap_cdc_send_chan #(
  parameter int PRESENT     = 1,
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             REGCLK,
  input  logic             RARREGRESETn,
  input  logic             SE,
  input  logic             SRCVALID,
  input  logic [WIDTH-1:0] SRCDATA,
  output logic             SRCREADY,
  output logic [WIDTH-1:0] REGDO,
  output logic             CDCREQ,
  input  logic             CDCACK,
  output logic             BUSY,
  output logic             DONE
);

  generate
    if (PRESENT != 0) begin : g_chan
      localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam int CW = $clog2(DEPTH + 1);

      typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;

      state_t                 state_q, state_d;
      logic [SYNC_STAGES-1:0] ack_sync_q;
      logic                   ack_s;
      logic [WIDTH-1:0]       mem_q [2**PW];
      logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
      logic [CW-1:0]          count_q;
      logic [WIDTH-1:0]       regdo_q;
      logic                   cdcreq_q, done_q;
      logic                   push, load, req_d, done_d;
      logic                   unused_se;

      assign unused_se = SE;

      always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
        if (!RARREGRESETn) ack_sync_q <= '0;
        else               ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], CDCACK};
      end
      assign ack_s = ack_sync_q[SYNC_STAGES-1];

      function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
      endfunction

      assign SRCREADY = (count_q != CW'(DEPTH));
      assign push     = SRCVALID & SRCREADY;

      // Storage needs no reset: only entries below count_q are ever read.
      always_ff @(posedge REGCLK) begin
        if (push) mem_q[wr_ptr_q] <= SRCDATA;
      end

      always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
        if (!RARREGRESETn) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
          if (load) rd_ptr_q <= ptr_inc(rd_ptr_q);
          case ({push, load})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
          endcase
        end
      end

      always_comb begin
        state_d = state_q;
        load    = 1'b0;
        req_d   = cdcreq_q;
        done_d  = 1'b0;
        case (state_q)
          IDLE: if (count_q != '0 && !ack_s) begin
            load    = 1'b1;
            state_d = SETUP;
          end
          SETUP: begin
            req_d   = 1'b1;
            state_d = REQ;
          end
          REQ: if (ack_s) begin
            req_d   = 1'b0;
            state_d = REL;
          end
          REL: if (!ack_s) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end

      always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
        if (!RARREGRESETn) begin
          state_q  <= IDLE;
          cdcreq_q <= 1'b0;
          done_q   <= 1'b0;
          regdo_q  <= '0;
        end else begin
          state_q  <= state_d;
          cdcreq_q <= req_d;
          done_q   <= done_d;
          if (load) regdo_q <= mem_q[rd_ptr_q];
        end
      end

      assign REGDO  = regdo_q;
      assign CDCREQ = cdcreq_q;
      assign DONE   = done_q;
      assign BUSY   = (count_q != '0) | (state_q != IDLE);

      ack_known: assert property (@(posedge REGCLK) disable iff (!RARREGRESETn)
                                  !$isunknown(CDCACK));
    end else begin : g_tieoff
      logic unused_p0;
      assign unused_p0 = ^{REGCLK, RARREGRESETn, SE, SRCVALID, SRCDATA, CDCACK};
      assign SRCREADY  = 1'b1;
      assign REGDO     = '0;
      assign CDCREQ    = 1'b0;
      assign BUSY      = 1'b0;
      assign DONE      = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cm0_dap_cdc_send_chan.sv
// Bench for cm0_dap_cdc_send_chan: vector table, directed corner cases and a
// randomised stream against a queue-based receiver model.
module tb_cm0_dap_cdc_send_chan;

  logic        clk = 1'b0;
  logic        rst_n, se, srcvalid;
  logic [31:0] srcdata, regdo;
  logic        srcready, cdcreq, cdcack, busy, done;
  logic [7:0]  regdo8;
  logic        srcready8, cdcreq8, busy8, done8;

  cm0_dap_cdc_send_chan #(.PRESENT(1), .WIDTH(32), .DEPTH(2), .SYNC_STAGES(2)) u_dut (
    .REGCLK(clk), .RARREGRESETn(rst_n), .SE(se), .SRCVALID(srcvalid),
    .SRCDATA(srcdata), .SRCREADY(srcready), .REGDO(regdo), .CDCREQ(cdcreq),
    .CDCACK(cdcack), .BUSY(busy), .DONE(done));

  cm0_dap_cdc_send_chan #(.PRESENT(0), .WIDTH(8), .DEPTH(2), .SYNC_STAGES(2)) u_p0 (
    .REGCLK(clk), .RARREGRESETn(rst_n), .SE(se), .SRCVALID(srcvalid),
    .SRCDATA(srcdata[7:0]), .SRCREADY(srcready8), .REGDO(regdo8), .CDCREQ(cdcreq8),
    .CDCACK(cdcack), .BUSY(busy8), .DONE(done8));

  always #5 clk = ~clk;

  int unsigned errors = 0, checks = 0;
  int unsigned pushes = 0, rx_n = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model of the ack as seen by the send-side logic (two-flop delay).
  logic [1:0] tb_sync;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_sync <= 2'b00;
    else        tb_sync <= {tb_sync[0], cdcack};
  end

  // Receiver: manual ack, or automatic 4-phase responder checking word order.
  bit          rx_auto = 1'b0, rx_rand = 1'b0, man_ack = 1'b0;
  int unsigned rx_dly = 0, rx_cnt = 0;
  initial cdcack = 1'b0;
  always @(posedge clk) begin
    #2;
    if (!rx_auto) cdcack = man_ack;
    else if (cdcreq && !cdcack) begin
      if (rx_cnt == 0 && rx_rand) rx_dly = $urandom_range(0, 10);
      if (rx_cnt >= rx_dly) begin
        cdcack = 1'b1;
        rx_cnt = 0;
        rx_n++;
        chk("rx_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("rx_word", 64'(regdo), 64'(exp_q.pop_front()));
      end else rx_cnt++;
    end else if (!cdcreq) begin
      cdcack = 1'b0;
      rx_cnt = 0;
    end
  end

  task automatic tick();
    logic [31:0] prev_do;
    logic        prev_hold;
    prev_do   = regdo;
    prev_hold = cdcreq | tb_sync[1];
    if (srcvalid && srcready) begin
      exp_q.push_back(srcdata);
      pushes++;
    end
    @(posedge clk);
    #1;
    if (regdo !== prev_do) chk("regdo_stable", 64'(prev_hold), 64'd0);
    chk("p0_tieoff", 64'({srcready8, regdo8, cdcreq8, done8, busy8}), 64'({1'b1, 8'h00, 3'b000}));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && busy; k++) tick();
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [31:0] data;
    int unsigned dly;
    int unsigned done_cyc;
  } vec_t;
  vec_t tab[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned done_at, pulses, target, rx0;
    logic        busy_at_done;

    tab[0] = '{32'hDEADBEEF, 3, 12};
    tab[1] = '{32'h00000000, 0, 9};
    tab[2] = '{32'hFFFFFFFF, 10, 19};
    tab[3] = '{32'h12345678, 1, 10};

    se = 1'b0; srcvalid = 1'b0; srcdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_regdo", 64'(regdo), 64'd0);
    chk("rst_cdcreq", 64'(cdcreq), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_srcready", 64'(srcready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Single-word transfers: REGDO at c2, CDCREQ at c3, DONE at 9+ack delay.
    rx_auto = 1'b1; rx_rand = 1'b0;
    foreach (tab[i]) begin
      rx_dly = tab[i].dly;
      srcvalid = 1'b1; srcdata = tab[i].data;
      tick();
      srcvalid = 1'b0; srcdata = $urandom;
      tick();
      chk("vec_regdo_c2", 64'(regdo), 64'(tab[i].data));
      tick();
      chk("vec_cdcreq_c3", 64'(cdcreq), 64'd1);
      done_at = 0; pulses = 0; busy_at_done = 1'b1;
      for (int c = 4; c <= 30; c++) begin
        tick();
        if (done) begin
          pulses++;
          if (done_at == 0) begin done_at = c; busy_at_done = busy; end
        end
      end
      chk("vec_done_cycle", 64'(done_at), 64'(tab[i].done_cyc));
      chk("vec_done_pulses", 64'(pulses), 64'd1);
      chk("vec_busy_at_done", 64'(busy_at_done), 64'd0);
    end

    // Full FIFO with ack held low, then release and check order.
    rx_auto = 1'b0; man_ack = 1'b0;
    rx0 = rx_n;
    for (int w = 1; w <= 3; w++) begin
      srcvalid = 1'b1; srcdata = 32'(w);
      tick();
    end
    srcvalid = 1'b0;
    chk("full_srcready", 64'(srcready), 64'd0);
    chk("full_pushes_held", 64'(exp_q.size()), 64'd3);
    rx_dly = 0; rx_auto = 1'b1;
    wait_idle();
    chk("full_rx_count", 64'(rx_n - rx0), 64'd3);
    chk("full_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random stream: 200 words, ack delays 0..10.
    rx_rand = 1'b1;
    rx0 = rx_n;
    target = pushes + 200;
    for (int k = 0; k < 20000 && pushes < target; k++) begin
      srcvalid = 1'($urandom_range(0, 1));
      srcdata  = $urandom;
      tick();
    end
    srcvalid = 1'b0;
    chk("rand_pushes", 64'(pushes), 64'(target));
    wait_idle();
    chk("rand_rx_count", 64'(rx_n - rx0), 64'd200);
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    rx_rand = 1'b0;

    // Asynchronous reset in the middle of REQ.
    rx_auto = 1'b0; man_ack = 1'b0;
    srcvalid = 1'b1; srcdata = 32'h5A5A5A5A;
    tick();
    srcvalid = 1'b0;
    for (int k = 0; k < 10 && !cdcreq; k++) tick();
    chk("midreq_cdcreq", 64'(cdcreq), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_regdo", 64'(regdo), 64'd0);
    chk("async_cdcreq", 64'(cdcreq), 64'd0);
    chk("async_srcready", 64'(srcready), 64'd1);
    chk("async_busy", 64'(busy), 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Stuck ack before the push blocks loading until it drops.
    man_ack = 1'b1;
    tick(); tick(); tick();
    srcvalid = 1'b1; srcdata = 32'h000000A5;
    tick();
    srcvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("stuck_hold", 64'({regdo, cdcreq}), 64'd0);
    end
    man_ack = 1'b0;
    rx_dly = 2; rx_auto = 1'b1;
    wait_idle();
    chk("stuck_regdo", 64'(regdo), 64'h000000A5);
    chk("stuck_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
